// File: rtl/best_arr_streamer.sv
// best_arr_streamer
//   Streams the best-index array out of a 1-cycle synchronous RAM into an
//   output FIFO in blocked traversal order. The order is px (half-row),
//   x (column block), y (row), xi (column within the block). A 2-entry
//   holding buffer absorbs the RAM read latency and FIFO back-pressure.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   send_best_arr     one-cycle start request (only accepted when idle)
//   busy              streaming in progress
//   done              one-cycle pulse in the cycle after the final enqueue
//   mem_rd_en         best-array read strobe
//   mem_rd_addr       best-array read address
//   mem_rd_data       read data, valid the cycle after mem_rd_en
//   out_fifo_wenq     FIFO enqueue strobe
//   out_fifo_wdata    enqueued word (mem_rd_data zero-extended)
//   out_fifo_wfull_n  FIFO can accept a word this cycle
module best_arr_streamer #(
   parameter int DATA_WIDTH = 11,
   parameter int IDX_WIDTH  = 9,
   parameter int ROW_SIZE   = 26,
   parameter int COL_SIZE   = 19,
   parameter int BLOCKING   = 4,
   parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  send_best_arr,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [IDX_WIDTH-1:0]  mem_rd_data,
   output logic                  out_fifo_wenq,
   output logic [DATA_WIDTH-1:0] out_fifo_wdata,
   input  logic                  out_fifo_wfull_n
);

   localparam int unsigned HALF = ROW_SIZE / 2;
   localparam int unsigned BLK  = BLOCKING;
   localparam int unsigned ROW  = ROW_SIZE;
   localparam int unsigned XB   = (HALF + BLK - 1) / BLK;
   localparam int unsigned XW   = (XB > 1) ? $clog2(XB) : 1;
   localparam int unsigned YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
   localparam int unsigned IW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state_q, state_d;
   logic                 px_q;
   logic [XW-1:0]        x_q;
   logic [YW-1:0]        y_q;
   logic [IW-1:0]        xi_q;
   logic                 rd_pending_q;
   logic [IDX_WIDTH-1:0] buf0_q, buf1_q;
   logic [1:0]           count_q;
   logic                 done_q;

   logic                 pop, issue, col_end, y_end, x_end, last_iter, last_pop;
   logic [1:0]           occ_after;

   // An iteration with x*BLOCKING+xi past the half-row is skipped, so the
   // xi loop ends early on the last (partial) block; xi=0 is never skipped.
   always_comb begin
      col_end   = (32'(x_q) * BLK + 32'(xi_q) + 32'd1 >= HALF) ||
                  (xi_q == IW'(BLOCKING - 1));
      y_end     = (y_q == YW'(COL_SIZE - 1));
      x_end     = (x_q == XW'(XB - 1));
      last_iter = px_q && x_end && y_end && col_end;
   end

   assign mem_rd_addr = ADDR_WIDTH'(32'(px_q) * HALF + 32'(y_q) * ROW +
                                    32'(x_q) * BLK + 32'(xi_q));

   // Credit check counts the slot freed by this cycle's pop, which is what
   // lets the stream sustain one word per cycle with only two entries.
   always_comb begin
      pop       = (count_q != 2'd0) && out_fifo_wfull_n;
      occ_after = count_q - {1'b0, pop} + {1'b0, rd_pending_q};
      issue     = (state_q == RUN) && (occ_after < 2'd2);
      last_pop  = (state_q == DRAIN) && pop && (count_q == 2'd1) && !rd_pending_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (send_best_arr)      state_d = RUN;
         RUN:     if (issue && last_iter) state_d = DRAIN;
         DRAIN:   if (last_pop)           state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last_pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
         xi_q <= '0;
      end else if (state_q == IDLE && send_best_arr) begin
         px_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
         xi_q <= '0;
      end else if (issue) begin
         if (!col_end) begin
            xi_q <= xi_q + 1'b1;
         end else begin
            xi_q <= '0;
            if (!y_end) begin
               y_q <= y_q + 1'b1;
            end else begin
               y_q <= '0;
               if (!x_end) begin
                  x_q <= x_q + 1'b1;
               end else begin
                  x_q  <= '0;
                  px_q <= ~px_q;
               end
            end
         end
      end
   end

   // Output buffer: buf0 is the head; rd_pending marks data arriving now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending_q <= 1'b0;
         buf0_q       <= '0;
         buf1_q       <= '0;
         count_q      <= '0;
      end else begin
         rd_pending_q <= issue;
         count_q      <= count_q + {1'b0, rd_pending_q} - {1'b0, pop};
         if (pop && rd_pending_q) begin
            if (count_q == 2'd1) begin
               buf0_q <= mem_rd_data;
            end else begin
               buf0_q <= buf1_q;
               buf1_q <= mem_rd_data;
            end
         end else if (pop) begin
            buf0_q <= buf1_q;
         end else if (rd_pending_q) begin
            if (count_q == 2'd0) buf0_q <= mem_rd_data;
            else                 buf1_q <= mem_rd_data;
         end
      end
   end

   assign mem_rd_en      = issue;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign out_fifo_wenq  = pop;
   assign out_fifo_wdata = DATA_WIDTH'(buf0_q);

endmodule

// File: tb/tb_best_arr_streamer.sv
// Testbench for best_arr_streamer: RAM model, FIFO back-pressure driver,
// and a reference order built from the nested-loop traversal rules.
module tb_best_arr_streamer;

   localparam int DW    = 11;
   localparam int IW    = 9;
   localparam int ROW   = 26;
   localparam int COL   = 19;
   localparam int BLK   = 4;
   localparam int AW    = 9;
   localparam int HALF  = ROW / 2;
   localparam int XB    = (HALF + BLK - 1) / BLK;
   localparam int TOTAL = ROW * COL;

   logic          clk = 1'b0;
   logic          rst_n, send_best_arr, busy, done, mem_rd_en;
   logic          out_fifo_wenq, out_fifo_wfull_n;
   logic [AW-1:0] mem_rd_addr;
   logic [IW-1:0] mem_rd_data;
   logic [DW-1:0] out_fifo_wdata;

   always #5 clk = ~clk;

   best_arr_streamer #(
      .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ROW_SIZE(ROW), .COL_SIZE(COL),
      .BLOCKING(BLK), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .send_best_arr(send_best_arr), .busy(busy),
      .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .out_fifo_wenq(out_fifo_wenq),
      .out_fifo_wdata(out_fifo_wdata), .out_fifo_wfull_n(out_fifo_wfull_n)
   );

   logic [IW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int words_seen, done_seen, outstanding, full_mode;
   bit mon_en;

   typedef struct {
      int full_mode;
      bit rand_mem;
      bit repulse;
      int exp_words;
      int exp_dones;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < (1 << AW); i++)
         mem[i] = rnd ? IW'($urandom_range(0, (1 << IW) - 1)) : IW'(i);
   endtask

   // Reference order straight from the loop nest and skip rule.
   task automatic build_expected();
      for (int px = 0; px < 2; px++)
         for (int x = 0; x < XB; x++)
            for (int y = 0; y < COL; y++)
               for (int xi = 0; xi < BLK; xi++)
                  if (x * BLK + xi < HALF)
                     exp_q.push_back(int'(mem[px * HALF + y * ROW + x * BLK + xi]));
   endtask

   task automatic begin_run();
      words_seen  = 0;
      done_seen   = 0;
      outstanding = 0;
      exp_q.delete();
      build_expected();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 send_best_arr = 1'b1;
      @(posedge clk); #1 send_best_arr = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_words(input int n, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (words_seen >= n) begin ok = 1'b1; break; end
      end
      check("reach_word_count", ok, 1);
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_wenq", out_fifo_wenq, 0);
      check("rst_addr", mem_rd_addr, 0);
      check("rst_wdata", out_fifo_wdata, 0);
   endtask

   task automatic run_one(input bit repulse);
      bit ok;
      begin_run();
      pulse_start();
      if (repulse) begin
         repeat (40) @(posedge clk);
         #1 send_best_arr = 1'b1;
         @(posedge clk); #1 send_best_arr = 1'b0;
      end
      wait_done(5000, ok);
      check("done_in_time", ok, 1);
      repeat (6) @(negedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0; send_best_arr = 1'b0; out_fifo_wfull_n = 1'b1;
      full_mode = 0; mon_en = 1'b0; mem_rd_data = '0;
      words_seen = 0; done_seen = 0; outstanding = 0;
      fill_mem(1'b0);

      vecs[0] = '{full_mode: 0, rand_mem: 1'b0, repulse: 1'b0, exp_words: TOTAL, exp_dones: 1};
      vecs[1] = '{full_mode: 1, rand_mem: 1'b0, repulse: 1'b0, exp_words: TOTAL, exp_dones: 1};
      vecs[2] = '{full_mode: 1, rand_mem: 1'b1, repulse: 1'b0, exp_words: TOTAL, exp_dones: 1};
      vecs[3] = '{full_mode: 0, rand_mem: 1'b1, repulse: 1'b1, exp_words: TOTAL, exp_dones: 1};
      vecs[4] = '{full_mode: 1, rand_mem: 1'b0, repulse: 1'b1, exp_words: TOTAL, exp_dones: 1};

      fork
         forever begin
            @(posedge clk); #1;
            case (full_mode)
               0:       out_fifo_wfull_n = 1'b1;
               1:       out_fifo_wfull_n = 1'($urandom_range(0, 1));
               default: out_fifo_wfull_n = 1'b0;
            endcase
         end
         forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
               if (out_fifo_wenq) begin
                  check("wenq_gated", out_fifo_wfull_n, 1);
                  if (exp_q.size() == 0) check("extra_word", 1, 0);
                  else                   check("word", out_fifo_wdata, exp_q.pop_front());
                  words_seen++;
               end
               if (mem_rd_en)
                  check("read_credit", (outstanding - int'(out_fifo_wenq)) < 2, 1);
               outstanding = outstanding + int'(mem_rd_en) - int'(out_fifo_wenq);
               if (done) begin
                  done_seen++;
                  check("done_not_busy", busy, 0);
                  check("done_retired", outstanding, 0);
               end
            end
         end
      join_none

      // Reset state and idle wait
      repeat (3) @(posedge clk);
      #1 check_reset_outputs();
      rst_n = 1'b1; mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", busy, 0);

      // Start latency and sustained rate with FIFO always ready
      begin_run();
      pulse_start();
      @(negedge clk); check("lat_busy_c1", busy, 1); check("lat_wenq_c1", out_fifo_wenq, 0);
      @(negedge clk); check("lat_wenq_c2", out_fifo_wenq, 0);
      for (int c = 3; c < 8; c++) begin
         @(negedge clk); check("lat_sustain", out_fifo_wenq, 1);
      end
      wait_done(5000, ok);
      check("lat_done_in_time", ok, 1);
      @(negedge clk); #1 check("done_one_cycle", done, 0);
      repeat (4) @(negedge clk);
      check("lat_words", words_seen, TOTAL);
      check("lat_dones", done_seen, 1);

      // Table of whole-run scenarios
      for (int v = 0; v < 5; v++) begin
         full_mode = vecs[v].full_mode;
         fill_mem(vecs[v].rand_mem);
         run_one(vecs[v].repulse);
         check("vec_words", words_seen, vecs[v].exp_words);
         check("vec_dones", done_seen, vecs[v].exp_dones);
         check("vec_left", exp_q.size(), 0);
      end
      full_mode = 0;
      fill_mem(1'b0);

      // Ten-cycle FIFO stall mid-stream
      begin_run();
      pulse_start();
      wait_words(50, 200);
      full_mode = 2;
      repeat (10) @(negedge clk);
      #1;
      check("stall_rd_en", mem_rd_en, 0);
      check("stall_outstanding", outstanding, 2);
      check("stall_wenq", out_fifo_wenq, 0);
      full_mode = 0;
      wait_done(5000, ok);
      check("stall_done_in_time", ok, 1);
      repeat (4) @(negedge clk);
      check("stall_words", words_seen, TOTAL);
      check("stall_dones", done_seen, 1);

      // Reset mid-stream, then a clean full run
      begin_run();
      pulse_start();
      wait_words(100, 300);
      @(posedge clk); #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); check("rst_no_wenq", out_fifo_wenq, 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_idle_wait", busy, 0);
      run_one(1'b0);
      check("after_rst_words", words_seen, TOTAL);
      check("after_rst_dones", done_seen, 1);

      // Back-to-back runs, second start in the done cycle
      begin_run();
      build_expected();
      pulse_start();
      wait_done(5000, ok);
      check("b2b_first_done", ok, 1);
      send_best_arr = 1'b1;
      @(posedge clk); #1 send_best_arr = 1'b0;
      wait_done(5000, ok);
      check("b2b_second_done", ok, 1);
      repeat (5) @(negedge clk);
      check("b2b_words", words_seen, 2 * TOTAL);
      check("b2b_dones", done_seen, 2);
      check("b2b_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/best_arr_streamer.md
BEST_ARR_STREAMER -- requirements
Module: best_arr_streamer

Interface
REQ-001 Param DATA_WIDTH, default 11, SHALL set the output FIFO word width.
REQ-002 Param IDX_WIDTH, default 9, SHALL set the best-index word width; IDX_WIDTH <= DATA_WIDTH.
REQ-003 Param ROW_SIZE, default 26, SHALL set patches per image row; it is even.
REQ-004 Param COL_SIZE, default 19, SHALL set the number of image rows.
REQ-005 Param BLOCKING, default 4, SHALL set the column-block width.
REQ-006 Param ADDR_WIDTH, default $clog2(ROW_SIZE*COL_SIZE), SHALL set the best-array address width.
REQ-007 Single clock, asynchronous active-low reset; ports: clk in 1 (rising edge); rst_n in 1 (async, active-low).
REQ-008 send_best_arr  in  1  one-cycle start request.
REQ-009 busy  out  1  streaming in progress.
REQ-010 done  out  1  one-cycle pulse after the last word is enqueued.
REQ-011 mem_rd_en  out  1  best-array read strobe.
REQ-012 mem_rd_addr  out  ADDR_WIDTH  best-array read address.
REQ-013 mem_rd_data  in  IDX_WIDTH  read data, valid the cycle after a strobe (1-cycle sync RAM).
REQ-014 out_fifo_wenq  out  1  enqueue strobe to the output FIFO.
REQ-015 out_fifo_wdata  out  DATA_WIDTH  enqueued word, mem_rd_data zero-extended.
REQ-016 out_fifo_wfull_n  in  1  FIFO can accept a word this cycle.

Function
REQ-017 Traversal order SHALL be nested loops, outermost first: px 0..1, x 0..XB-1 with XB=ceil((ROW_SIZE/2)/BLOCKING), y 0..COL_SIZE-1, xi 0..BLOCKING-1.
REQ-018 An iteration SHALL be skipped when x*BLOCKING+xi >= ROW_SIZE/2; skipped iterations cost zero cycles.
REQ-019 Address SHALL be px*(ROW_SIZE/2) + y*ROW_SIZE + x*BLOCKING + xi; total words = ROW_SIZE*COL_SIZE (494 at defaults).
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN: IDLE->RUN on send_best_arr; RUN->DRAIN after the last read issues; DRAIN->IDLE when the buffer is empty and reads are all retired.
REQ-021 send_best_arr SHALL be ignored when not in IDLE.
REQ-022 A 2-entry output buffer SHALL absorb read latency; a read SHALL issue only when buffer occupancy plus in-flight reads < 2.
REQ-023 out_fifo_wenq SHALL equal (buffer non-empty) AND out_fifo_wfull_n; out_fifo_wdata SHALL be the buffer head; the head pops on wenq.
REQ-024 Simultaneous pop and fill SHALL keep occupancy constant; no word is ever dropped or duplicated.
REQ-025 With out_fifo_wfull_n held high, the first out_fifo_wenq SHALL occur in the 3rd cycle after the edge sampling send_best_arr, then 1 word/cycle sustained.
REQ-026 done SHALL pulse exactly one cycle, in the cycle after the final enqueue; busy SHALL be high from the cycle after start through the final-enqueue cycle.
REQ-027 A new send_best_arr in the done cycle or later SHALL restart the full traversal from address 0.

Reset
REQ-028 While rst_n=0: state IDLE, counters 0, buffer empty, and busy, done, mem_rd_en, out_fifo_wenq all 0; mem_rd_addr and out_fifo_wdata 0.
REQ-029 Reset asserted mid-stream SHALL abort immediately with no further enqueue; after release the block waits in IDLE for send_best_arr.

Verification
REQ-030 Memory word = address, wfull_n=1, pulse start -> 494 words: 0,1,2,3,26,27,28,29,...; x=3 block yields 12,38,64,...; px=1 starts 13,14,15,16; last word 493; done once.
REQ-031 Random wfull_n (50% low) -> same 494-word sequence, no loss or duplication, wenq never high while wfull_n=0.
REQ-032 wfull_n low for 10 cycles mid-stream -> mem_rd_en stalls after at most 2 outstanding, stream resumes in order.
REQ-033 send_best_arr re-pulsed while busy -> ignored; exactly 494 words and a single done.
REQ-034 rst_n low at word 100 -> outputs 0 within the reset cycle; new start -> full sequence from 0.
REQ-035 Two back-to-back runs with a start in the done cycle -> 988 words total, two done pulses.
